// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: holds the fetch PC, requests words from instruction
// memory over a req/ack handshake, registers the returned instruction and
// absorbs one word in a skid buffer when decode stalls.
// Optional feature macro: FETCH_REDIRECT_EN adds Redirect/RedirectPC for
// control-flow redirection; without it the PC is strictly sequential.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'd4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  input  logic        Stall,
`ifdef FETCH_REDIRECT_EN
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
`endif
  output logic        Valid,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [6:0]  Opcode,
  output logic [2:0]  Funct3,
  output logic [6:0]  Funct7,
  output logic [4:0]  Rd,
  output logic [4:0]  Rs1,
  output logic [4:0]  Rs2,
  output logic        Illegal
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  // Opcodes the downstream decoder supports: R-type, store, LUI, OP-IMM, load.
  localparam int          NUM_LEGAL = 5;
  localparam logic [34:0] LEGAL_OPS = {7'b0110011, 7'b0100011, 7'b0110111,
                                       7'b0010011, 7'b0000011};

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic        valid_reg, valid_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pc_reg, pc_next;
  logic        illegal_reg, illegal_next;
  logic [31:0] skid_instr_reg, skid_instr_next;
  logic [31:0] skid_pc_reg, skid_pc_next;
`ifdef FETCH_REDIRECT_EN
  logic        pending_reg, pending_next;
  logic [31:0] redirect_pc_reg, redirect_pc_next;
`endif

  logic                 consume;
  logic [31:0]          load_word;
  logic [NUM_LEGAL-1:0] legal_hit;
  logic                 load_illegal;

  assign consume   = valid_reg & ~Stall;
  // The only word that can be loaded from SKID is the skid entry; elsewhere
  // it comes straight from memory.
  assign load_word = (state_reg == ST_SKID) ? skid_instr_reg : IMemData;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEGAL; gi++) begin : g_legal
      assign legal_hit[gi] = (load_word[6:0] == LEGAL_OPS[gi*7 +: 7]);
    end
  endgenerate
  assign load_illegal = ~|legal_hit;

  // Next-state and datapath update for the fetch FSM
  always_comb begin
    state_next      = state_reg;
    fetch_pc_next   = fetch_pc_reg;
    valid_next      = valid_reg;
    instr_next      = instr_reg;
    pc_next         = pc_reg;
    illegal_next    = illegal_reg;
    skid_instr_next = skid_instr_reg;
    skid_pc_next    = skid_pc_reg;
`ifdef FETCH_REDIRECT_EN
    pending_next     = pending_reg;
    redirect_pc_next = redirect_pc_reg;
`endif
    case (state_reg)
      ST_BOOT: state_next = ST_FETCH;
      ST_FETCH: begin
        if (IMemAck) begin
          fetch_pc_next = fetch_pc_reg + PC_STEP;
          if (!valid_reg || consume) begin
            instr_next   = IMemData;
            pc_next      = fetch_pc_reg;
            valid_next   = 1'b1;
            illegal_next = load_illegal;
          end else begin
            // Decode is holding the current word: park the new one.
            skid_instr_next = IMemData;
            skid_pc_next    = fetch_pc_reg;
            state_next      = ST_SKID;
          end
        end else if (consume) begin
          valid_next   = 1'b0;
          instr_next   = NOP_INSTR;
          illegal_next = 1'b0;
        end
      end
      ST_SKID: begin
        if (consume) begin
          instr_next   = skid_instr_reg;
          pc_next      = skid_pc_reg;
          valid_next   = 1'b1;
          illegal_next = load_illegal;
          state_next   = ST_FETCH;
        end
      end
      default: state_next = ST_BOOT;
    endcase
`ifdef FETCH_REDIRECT_EN
    // Redirect overrides everything above; an un-acked request is left on
    // the bus untouched and its data thrown away when it finally returns.
    if (Redirect) begin
      valid_next      = 1'b0;
      instr_next      = NOP_INSTR;
      illegal_next    = 1'b0;
      pc_next         = pc_reg;
      skid_instr_next = skid_instr_reg;
      skid_pc_next    = skid_pc_reg;
      state_next      = ST_FETCH;
      if (state_reg == ST_FETCH && !IMemAck) begin
        fetch_pc_next    = fetch_pc_reg;
        pending_next     = 1'b1;
        redirect_pc_next = RedirectPC;
      end else begin
        fetch_pc_next = RedirectPC;
        pending_next  = 1'b0;
      end
    end else if (pending_reg && state_reg == ST_FETCH && IMemAck) begin
      valid_next      = 1'b0;
      instr_next      = NOP_INSTR;
      illegal_next    = 1'b0;
      pc_next         = pc_reg;
      skid_instr_next = skid_instr_reg;
      skid_pc_next    = skid_pc_reg;
      state_next      = ST_FETCH;
      fetch_pc_next   = redirect_pc_reg;
      pending_next    = 1'b0;
    end
`endif
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_BOOT;
      fetch_pc_reg   <= RESET_PC;
      valid_reg      <= 1'b0;
      instr_reg      <= NOP_INSTR;
      pc_reg         <= RESET_PC;
      illegal_reg    <= 1'b0;
      skid_instr_reg <= NOP_INSTR;
      skid_pc_reg    <= RESET_PC;
`ifdef FETCH_REDIRECT_EN
      pending_reg     <= 1'b0;
      redirect_pc_reg <= RESET_PC;
`endif
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      valid_reg      <= valid_next;
      instr_reg      <= instr_next;
      pc_reg         <= pc_next;
      illegal_reg    <= illegal_next;
      skid_instr_reg <= skid_instr_next;
      skid_pc_reg    <= skid_pc_next;
`ifdef FETCH_REDIRECT_EN
      pending_reg     <= pending_next;
      redirect_pc_reg <= redirect_pc_next;
`endif
    end
  end

  assign IMemReq  = (state_reg == ST_FETCH);
  assign IMemAddr = fetch_pc_reg;
  assign Valid    = valid_reg;
  assign Instr    = instr_reg;
  assign PC       = pc_reg;
  assign Illegal  = illegal_reg;
  assign Opcode   = instr_reg[6:0];
  assign Funct3   = instr_reg[14:12];
  assign Funct7   = instr_reg[31:25];
  assign Rd       = instr_reg[11:7];
  assign Rs1      = instr_reg[19:15];
  assign Rs2      = instr_reg[24:20];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed scenarios plus a
// randomized run against an in-order instruction-stream reference model.
module tb_instr_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, ack, stall;
  logic [31:0] data;
  logic        req, valid, illegal;
  logic [31:0] addr, instr, pc;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;

  logic        w_ack, w_stall;
  logic [31:0] w_data;
  logic        w_req, w_valid, w_illegal;
  logic [31:0] w_addr, w_instr, w_pc;
  logic [6:0]  w_opcode, w_funct7;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rd, w_rs1, w_rs2;

  logic        redirect;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_stage u_dut (
    .clk(clk), .rst(rst), .IMemReq(req), .IMemAddr(addr), .IMemAck(ack),
    .IMemData(data), .Stall(stall),
`ifdef FETCH_REDIRECT_EN
    .Redirect(redirect), .RedirectPC(redirect_pc),
`endif
    .Valid(valid), .Instr(instr), .PC(pc), .Opcode(opcode), .Funct3(funct3),
    .Funct7(funct7), .Rd(rd), .Rs1(rs1), .Rs2(rs2), .Illegal(illegal)
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .IMemReq(w_req), .IMemAddr(w_addr), .IMemAck(w_ack),
    .IMemData(w_data), .Stall(w_stall),
`ifdef FETCH_REDIRECT_EN
    .Redirect(1'b0), .RedirectPC(32'h0),
`endif
    .Valid(w_valid), .Instr(w_instr), .PC(w_pc), .Opcode(w_opcode), .Funct3(w_funct3),
    .Funct7(w_funct7), .Rd(w_rd), .Rs1(w_rs1), .Rs2(w_rs2), .Illegal(w_illegal)
  );

  // Memory contents: a hashed word with an opcode drawn from a mix of
  // supported and unsupported values.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0]  op;
    h = (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    case (h[10:8])
      3'd0: op = 7'b0110011;
      3'd1: op = 7'b0100011;
      3'd2: op = 7'b0110111;
      3'd3: op = 7'b0010011;
      3'd4: op = 7'b0000011;
      3'd5: op = 7'b1101111;
      3'd6: op = 7'b1100011;
      default: op = 7'b0010111;
    endcase
    return {h[31:7], op};
  endfunction

  function automatic logic model_illegal(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    return !(op == 7'b0110011 || op == 7'b0100011 || op == 7'b0110111 ||
             op == 7'b0010011 || op == 7'b0000011);
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; ack = 1'b0; stall = 1'b0; data = 32'h0;
    w_ack = 1'b0; w_stall = 1'b0; w_data = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; ack = 1'b1; data = 32'h0000_006F; stall = 1'b0;
    w_ack = 1'b0; w_stall = 1'b0; w_data = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0;
    cycle();
    cycle();
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid); end
    n_checks++; if (instr !== NOP) begin n_fail++; $display("FAIL reset_instr got %h exp %h", instr, NOP); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", pc); end
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b exp 0", illegal); end
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", req); end
    rst = 1'b0; ack = 1'b0;
    cycle();
    n_checks++; if (req !== 1'b1 || addr !== 32'h0) begin n_fail++; $display("FAIL boot_to_fetch req=%b addr=%h exp 1/0", req, addr); end
    // Reset in the middle of a request: the ack is ignored and req drops.
    ack = 1'b1; data = 32'h0050_0093; rst = 1'b1;
    cycle();
    n_checks++; if (req !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL midreq_reset req=%b valid=%b exp 0/0", req, valid); end
    rst = 1'b0; ack = 1'b0;
    cycle();
    n_checks++; if (req !== 1'b1 || addr !== 32'h0 || valid !== 1'b0) begin n_fail++; $display("FAIL refetch req=%b addr=%h valid=%b", req, addr, valid); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    do_reset();
    n_checks++; if (addr !== 32'h0 || valid !== 1'b0) begin n_fail++; $display("FAIL basic_addr0 addr=%h valid=%b", addr, valid); end
    ack = 1'b1; data = 32'h0050_0093;
    cycle();
    n_checks++; if (valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h0050_0093) begin n_fail++; $display("FAIL basic_first valid=%b pc=%h instr=%h", valid, pc, instr); end
    n_checks++; if (opcode !== 7'b0010011 || rd !== 5'd1 || illegal !== 1'b0) begin n_fail++; $display("FAIL basic_first_fields op=%b rd=%0d ill=%b", opcode, rd, illegal); end
    n_checks++; if (addr !== 32'h4 || req !== 1'b1) begin n_fail++; $display("FAIL basic_addr4 addr=%h req=%b", addr, req); end
    data = 32'h00A0_0113;
    cycle();
    n_checks++; if (valid !== 1'b1 || pc !== 32'h4 || rd !== 5'd2 || rs1 !== 5'd0 || opcode !== 7'b0010011) begin n_fail++; $display("FAIL basic_second valid=%b pc=%h rd=%0d op=%b", valid, pc, rd, opcode); end
    ack = 1'b0;
    cycle();
    n_checks++; if (valid !== 1'b0 || instr !== NOP) begin n_fail++; $display("FAIL basic_drain valid=%b instr=%h", valid, instr); end
    $display("test_basic pc0 and pc4 delivered");
  endtask

  task automatic test_delayed_ack();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (req !== 1'b1 || addr !== 32'h0 || valid !== 1'b0) begin n_fail++; $display("FAIL delay_wait%0d req=%b addr=%h valid=%b", i, req, addr, valid); end
      cycle();
    end
    ack = 1'b1; data = 32'h0020_8233;
    cycle();
    ack = 1'b0;
    n_checks++; if (valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h0020_8233) begin n_fail++; $display("FAIL delay_load valid=%b pc=%h instr=%h", valid, pc, instr); end
    n_checks++; if (funct7 !== 7'd0 || rs2 !== 5'd2 || rs1 !== 5'd1 || rd !== 5'd4 || funct3 !== 3'd0) begin n_fail++; $display("FAIL delay_fields f7=%h rs2=%0d rs1=%0d rd=%0d", funct7, rs2, rs1, rd); end
    $display("test_delayed_ack done");
  endtask

  task automatic test_stall_skid();
    do_reset();
    ack = 1'b1; data = mem_word(32'h0);
    cycle();
    data = mem_word(32'h4);
    cycle();
    stall = 1'b1; data = mem_word(32'h8);
    cycle();
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (req !== 1'b0 || valid !== 1'b1 || pc !== 32'h4) begin n_fail++; $display("FAIL skid_hold%0d req=%b valid=%b pc=%h", i, req, valid, pc); end
      cycle();
    end
    stall = 1'b0;
    cycle();
    n_checks++; if (valid !== 1'b1 || pc !== 32'h8 || instr !== mem_word(32'h8)) begin n_fail++; $display("FAIL skid_release pc=%h instr=%h", pc, instr); end
    n_checks++; if (req !== 1'b1 || addr !== 32'hC) begin n_fail++; $display("FAIL skid_nextaddr req=%b addr=%h exp C", req, addr); end
    ack = 1'b1; data = mem_word(32'hC);
    cycle();
    ack = 1'b0;
    n_checks++; if (valid !== 1'b1 || pc !== 32'hC || instr !== mem_word(32'hC)) begin n_fail++; $display("FAIL skid_after pc=%h instr=%h", pc, instr); end
    $display("test_stall_skid pc8 then pcC");
  endtask

  task automatic test_illegal();
    do_reset();
    ack = 1'b1; data = 32'h0000_006F;
    cycle();
    ack = 1'b0;
    n_checks++; if (valid !== 1'b1 || illegal !== 1'b1 || opcode !== 7'b1101111) begin n_fail++; $display("FAIL illegal_jal valid=%b ill=%b op=%b", valid, illegal, opcode); end
    cycle();
    n_checks++; if (valid !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_clear valid=%b ill=%b", valid, illegal); end
    $display("test_illegal done");
  endtask

  task automatic test_wrap();
    do_reset();
    n_checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0 req=%b addr=%h", w_req, w_addr); end
    w_ack = 1'b1; w_data = 32'h0050_0093;
    cycle();
    n_checks++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_first pc=%h addr=%h", w_pc, w_addr); end
    w_data = 32'h00A0_0113;
    cycle();
    w_ack = 1'b0;
    n_checks++; if (w_valid !== 1'b1 || w_pc !== 32'h0 || w_rd !== 5'd2) begin n_fail++; $display("FAIL wrap_second pc=%h rd=%0d", w_pc, w_rd); end
    $display("test_wrap done");
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, exp_fetch, w;
    int lat, consumed;
    logic waiting;
    do_reset();
    exp_pc = 32'h0; exp_fetch = 32'h0; consumed = 0; waiting = 1'b0; lat = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      stall = ($urandom_range(0, 3) == 0);
      if (valid && !stall) begin
        w = mem_word(exp_pc);
        n_checks++; if (pc !== exp_pc || instr !== w) begin n_fail++; $display("FAIL rand_stream pc=%h instr=%h exp %h/%h", pc, instr, exp_pc, w); end
        n_checks++; if (opcode !== w[6:0] || rd !== w[11:7] || funct3 !== w[14:12] || rs1 !== w[19:15] || rs2 !== w[24:20] || funct7 !== w[31:25]) begin n_fail++; $display("FAIL rand_fields instr=%h exp %h", instr, w); end
        n_checks++; if (illegal !== model_illegal(w)) begin n_fail++; $display("FAIL rand_illegal got %b exp %b", illegal, model_illegal(w)); end
        $display("consume pc=%h instr=%h illegal=%b", pc, instr, illegal);
        exp_pc += 32'd4;
        consumed++;
      end
      ack = 1'b0;
      if (req) begin
        if (!waiting) begin waiting = 1'b1; lat = $urandom_range(0, 3); end
        if (lat == 0) begin
          n_checks++; if (addr !== exp_fetch) begin n_fail++; $display("FAIL rand_fetch_addr got %h exp %h", addr, exp_fetch); end
          ack = 1'b1; data = mem_word(addr);
          exp_fetch += 32'd4;
          waiting = 1'b0;
        end else begin
          lat--;
        end
      end
      cycle();
    end
    stall = 1'b0; ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (valid) begin
        n_checks++; if (pc !== exp_pc || instr !== mem_word(exp_pc)) begin n_fail++; $display("FAIL drain_stream pc=%h exp %h", pc, exp_pc); end
        exp_pc += 32'd4;
        consumed++;
      end
      cycle();
    end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL drain_timeout valid=%b exp 0", valid); end
    n_checks++; if (exp_pc !== exp_fetch) begin n_fail++; $display("FAIL no_drop consumed_up_to=%h fetched_up_to=%h", exp_pc, exp_fetch); end
    n_checks++; if (consumed < 20) begin n_fail++; $display("FAIL rand_progress consumed=%0d exp >=20", consumed); end
    $display("test_random consumed %0d instructions", consumed);
  endtask

`ifdef FETCH_REDIRECT_EN
  task automatic test_redirect();
    do_reset();
    ack = 1'b1; data = mem_word(32'h0);
    cycle();
    data = mem_word(32'h4);
    cycle();
    ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect = 1'b0;
    n_checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h8) begin n_fail++; $display("FAIL redir_hold valid=%b req=%b addr=%h", valid, req, addr); end
    ack = 1'b1; data = mem_word(32'h8);
    cycle();
    n_checks++; if (valid !== 1'b0 || addr !== 32'h100) begin n_fail++; $display("FAIL redir_discard valid=%b addr=%h", valid, addr); end
    data = mem_word(32'h100);
    cycle();
    ack = 1'b0;
    n_checks++; if (valid !== 1'b1 || pc !== 32'h100 || instr !== mem_word(32'h100)) begin n_fail++; $display("FAIL redir_target valid=%b pc=%h", valid, pc); end
    $display("test_redirect done");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_delayed_ack();
    test_stall_skid();
    test_illegal();
    test_wrap();
    test_random();
`ifdef FETCH_REDIRECT_EN
    test_redirect();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
